// File: rtl/downscale_pkg.sv
// Shared types for the streaming 2x downscale engine.
package downscale_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_TOP,
      S_WAIT_TOP,
      S_REQ_BOT,
      S_WAIT_BOT,
      S_WRITE,
      S_FIN
   } state_e;

   typedef enum logic {
      MODE_AVG = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   // Added before the divide-by-4 so the box average rounds to nearest.
   localparam int unsigned ROUND_BIAS = 2;

endpackage

// File: rtl/downscale_stream_simd_if.sv
// Memory-side bus of the downscale engine: N-lane read port and a single write port.
interface downscale_stream_simd_if #(
   parameter int N      = 4,
   parameter int ADDR_W = 16
) ();

   logic [N-1:0]             rd_req;
   logic [N-1:0][ADDR_W-1:0] rd_addr;
   logic [N-1:0]             rd_valid;
   logic [N-1:0][7:0]        rd_data;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [7:0]               wr_data;

   modport master (
      output rd_req, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_valid, rd_data
   );

   modport slave (
      input  rd_req, rd_addr, wr_en, wr_addr, wr_data,
      output rd_valid, rd_data
   );

endinterface

// File: rtl/downscale_stream_simd_pair_reduce.sv
// Combinational 2x2 reduction of NP horizontal pixel pairs from two source rows.
module pair_reduce
   import downscale_pkg::*;
#(
   parameter int NP = 2
) (
   input  mode_e                 mode,
   input  logic [2*NP-1:0][7:0]  top,
   input  logic [2*NP-1:0][7:0]  bot,
   output logic [NP-1:0][7:0]    res
);

   for (genvar j = 0; j < NP; j++) begin : g_pair
      logic [9:0] sum;
      // Four 8-bit pixels plus the bias fit in 10 bits, so no overflow.
      assign sum    = {2'b00, top[2*j]} + {2'b00, top[2*j+1]}
                    + {2'b00, bot[2*j]} + {2'b00, bot[2*j+1]};
      assign res[j] = (mode == MODE_DEC) ? top[2*j]
                                         : 8'((sum + 10'(ROUND_BIAS)) >> 2);
   end

endmodule

// File: rtl/downscale_stream_simd.sv
// Streaming 2x downscaler: reads one N-pixel chunk from each of two rows, writes N/2 results.
//
// state      | meaning
// S_IDLE     | waiting for start
// S_REQ_TOP  | issue N lane reads for the even source row
// S_WAIT_TOP | collect lanes until all N captured
// S_REQ_BOT  | issue N lane reads for the odd source row
// S_WAIT_BOT | collect lanes until all N captured
// S_WRITE    | emit N/2 reduced pixels on consecutive cycles
// S_FIN      | pulse done, drop busy
module downscale_stream_simd
   import downscale_pkg::*;
#(
   parameter int SRC_W    = 32,
   parameter int SRC_H    = 32,
   parameter int N        = 4,
   parameter int ADDR_W   = 16,
   parameter int DST_BASE = SRC_W * SRC_H
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic mode,
   output logic busy,
   output logic done,
   downscale_stream_simd_if.master mem
);

   localparam int NP = N / 2;
   localparam int JW = (NP > 1) ? $clog2(NP) : 1;
   localparam logic [ADDR_W-1:0] CCOL_LAST = ADDR_W'(SRC_W - N);
   localparam logic [ADDR_W-1:0] OROW_LAST = ADDR_W'(SRC_H / 2 - 1);

   state_e              state;
   mode_e               mode_q;
   logic [ADDR_W-1:0]   orow;
   logic [ADDR_W-1:0]   ccol;
   logic [JW-1:0]       j;
   logic [N-1:0]        mask;
   logic [N-1:0]        mask_nxt;
   logic [N-1:0][7:0]   top;
   logic [N-1:0][7:0]   bot;
   logic [NP-1:0][7:0]  red;
   logic [ADDR_W-1:0]   row_top;
   logic [ADDR_W-1:0]   row_bot;
   logic [ADDR_W-1:0]   dst_chunk;

   // Same-cycle arrivals count toward completion, so the FSM never idles a cycle.
   assign mask_nxt  = mask | mem.rd_valid;
   assign row_top   = orow * ADDR_W'(2 * SRC_W);
   assign row_bot   = row_top + ADDR_W'(SRC_W);
   assign dst_chunk = ADDR_W'(DST_BASE) + orow * ADDR_W'(SRC_W / 2) + (ccol >> 1);

   pair_reduce #(.NP(NP)) u_reduce (
      .mode (mode_q),
      .top  (top),
      .bot  (bot),
      .res  (red)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         mode_q      <= MODE_AVG;
         orow        <= '0;
         ccol        <= '0;
         j           <= '0;
         mask        <= '0;
         top         <= '0;
         bot         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem.rd_req  <= '0;
         mem.rd_addr <= '0;
         mem.wr_en   <= 1'b0;
         mem.wr_addr <= '0;
         mem.wr_data <= '0;
      end else begin
         mem.rd_req <= '0;
         mem.wr_en  <= 1'b0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_q <= mode_e'(mode);
                  orow   <= '0;
                  ccol   <= '0;
                  j      <= '0;
                  busy   <= 1'b1;
                  state  <= S_REQ_TOP;
               end
            end
            S_REQ_TOP, S_REQ_BOT: begin
               mem.rd_req <= '1;
               mask       <= '0;
               for (int k = 0; k < N; k++) begin
                  mem.rd_addr[k] <= ((state == S_REQ_BOT) ? row_bot : row_top)
                                  + ccol + ADDR_W'(k);
               end
               state <= (state == S_REQ_TOP) ? S_WAIT_TOP : S_WAIT_BOT;
            end
            S_WAIT_TOP, S_WAIT_BOT: begin
               for (int k = 0; k < N; k++) begin
                  if (mem.rd_valid[k] && !mask[k]) begin
                     if (state == S_WAIT_TOP) top[k] <= mem.rd_data[k];
                     else                     bot[k] <= mem.rd_data[k];
                  end
               end
               mask <= mask_nxt;
               if (&mask_nxt) state <= (state == S_WAIT_TOP) ? S_REQ_BOT : S_WRITE;
            end
            S_WRITE: begin
               mem.wr_en   <= 1'b1;
               mem.wr_addr <= dst_chunk + ADDR_W'(j);
               mem.wr_data <= red[j];
               if (j == JW'(NP - 1)) begin
                  j <= '0;
                  if (ccol == CCOL_LAST) begin
                     ccol <= '0;
                     if (orow == OROW_LAST) begin
                        orow  <= '0;
                        state <= S_FIN;
                     end else begin
                        orow  <= orow + 1'b1;
                        state <= S_REQ_TOP;
                     end
                  end else begin
                     ccol  <= ccol + ADDR_W'(N);
                     state <= S_REQ_TOP;
                  end
               end else begin
                  j <= j + 1'b1;
               end
            end
            S_FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
